// File: rtl/run_ctrl.sv
// run_ctrl: staged reset generator and end-of-run monitor for the pipelined core.
//
// After the board reset is released, the NUM_RST active-low core resets are let go one by
// one: channel k goes high after edge RST_CYCLES-1 + k*STAGE_GAP, counting the first edge
// that samples i_reset high as edge 0. The edge that releases the last channel also enters
// RUN. In RUN the block counts cycles and retired instructions. It ends the run with one of
// three results, in priority order:
//   PASS    - HALT_PC retires.
//   STALL   - STALL_LIMIT consecutive idle cycles.
//   TIMEOUT - TIMEOUT_CYCLES run cycles.
// DONE is sticky until i_reset goes low again.
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_reset       synchronous active-low reset
//   i_pc_debug    PC of the instruction retiring this cycle
//   i_insn_vld    a valid instruction retires this cycle
//   o_core_rst_n  staged active-low resets to the core sub-blocks
//   o_running     high while in RUN
//   o_done        sticky end-of-run flag
//   o_status      00 none, 01 PASS, 10 STALL, 11 TIMEOUT
//   o_cycle_cnt   RUN cycles elapsed (saturating)
//   o_insn_cnt    instructions retired in RUN (saturating)
//
// CNT_W must not exceed 63 so that the timeout compare fits in 64 bits.

module run_ctrl #(
    parameter int unsigned     NUM_RST        = 2,
    parameter int unsigned     RST_CYCLES     = 4,
    parameter int unsigned     STAGE_GAP      = 2,
    parameter logic [31:0]     HALT_PC        = 32'h0000_0FFC,
    parameter int unsigned     STALL_LIMIT    = 16,
    parameter longint unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned     CNT_W          = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [31:0]        i_pc_debug,
    input  logic               i_insn_vld,
    output logic [NUM_RST-1:0] o_core_rst_n,
    output logic               o_running,
    output logic               o_done,
    output logic [1:0]         o_status,
    output logic [CNT_W-1:0]   o_cycle_cnt,
    output logic [CNT_W-1:0]   o_insn_cnt
);

    // Hold count at which the last channel is released.
    localparam int unsigned HoldLast = RST_CYCLES + (NUM_RST - 1) * STAGE_GAP;
    localparam int unsigned HoldW    = $clog2(HoldLast + 1);
    localparam int unsigned StallW   = $clog2(STALL_LIMIT + 1);

    localparam logic [HoldW-1:0]  HoldOne  = HoldW'(1);
    localparam logic [StallW-1:0] StallOne = StallW'(1);
    localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
    localparam logic [CNT_W:0]    WideOne  = (CNT_W + 1)'(1);

    localparam logic [1:0] StatNone    = 2'b00;
    localparam logic [1:0] StatPass    = 2'b01;
    localparam logic [1:0] StatStall   = 2'b10;
    localparam logic [1:0] StatTimeout = 2'b11;

    typedef enum logic [1:0] {
        StHold,
        StRun,
        StDone
    } state_e;

    state_e               state_q;
    logic [HoldW-1:0]     hold_cnt_q;
    logic [StallW-1:0]    stall_cnt_q;
    logic [NUM_RST-1:0]   rst_n_q;
    logic                 running_q;
    logic                 done_q;
    logic [1:0]           status_q;
    logic [CNT_W-1:0]     cycle_cnt_q;
    logic [CNT_W-1:0]     insn_cnt_q;

    // Next-value helpers
    logic [HoldW-1:0]     hold_inc;
    logic [NUM_RST-1:0]   release_d;
    logic                 release_all;
    logic [StallW-1:0]    stall_inc;
    logic                 cycle_sat;
    logic [CNT_W-1:0]     cycle_inc;
    logic [CNT_W:0]       cycle_wide;
    logic [CNT_W-1:0]     insn_inc;
    logic                 halt_hit;
    logic                 stall_hit;
    logic                 timeout_hit;
    logic                 end_hit;
    logic [1:0]           end_code;

    // Reset staging: channel k releases once the incremented hold count reaches its threshold.
    always_comb begin
        hold_inc  = hold_cnt_q + HoldOne;
        release_d = '0;
        for (int unsigned k = 0; k < NUM_RST; k++) begin
            release_d[k] = (32'(hold_inc) >= (RST_CYCLES + STAGE_GAP * k));
        end
        release_all = release_d[NUM_RST-1];
    end

    // Run monitoring: counters and end-of-run detection from the current-cycle inputs.
    always_comb begin
        stall_inc   = stall_cnt_q + StallOne;
        cycle_sat   = &cycle_cnt_q;
        cycle_inc   = cycle_sat ? cycle_cnt_q : cycle_cnt_q + CntOne;
        insn_inc    = (&insn_cnt_q) ? insn_cnt_q : insn_cnt_q + CntOne;
        // One bit wider, so TIMEOUT_CYCLES = 2^CNT_W does not alias to zero.
        cycle_wide  = {1'b0, cycle_cnt_q} + WideOne;

        halt_hit    = i_insn_vld && (i_pc_debug == HALT_PC);
        stall_hit   = !i_insn_vld && (32'(stall_inc) >= STALL_LIMIT);
        // A saturated counter can never reach a limit beyond its range.
        timeout_hit = !cycle_sat && (64'(cycle_wide) == TIMEOUT_CYCLES);

        end_hit  = halt_hit || stall_hit || timeout_hit;
        end_code = StatNone;
        if (halt_hit) begin
            end_code = StatPass;
        end else if (stall_hit) begin
            end_code = StatStall;
        end else if (timeout_hit) begin
            end_code = StatTimeout;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= StHold;
            hold_cnt_q  <= '0;
            stall_cnt_q <= '0;
            rst_n_q     <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= StatNone;
            cycle_cnt_q <= '0;
            insn_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    hold_cnt_q <= hold_inc;
                    // Released channels stay released.
                    rst_n_q    <= rst_n_q | release_d;
                    if (release_all) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end
                end
                StRun: begin
                    // The end-condition cycle is still counted.
                    cycle_cnt_q <= cycle_inc;
                    if (i_insn_vld) begin
                        insn_cnt_q  <= insn_inc;
                        stall_cnt_q <= '0;
                    end else begin
                        stall_cnt_q <= stall_inc;
                    end
                    if (end_hit) begin
                        state_q   <= StDone;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        status_q  <= end_code;
                    end
                end
                StDone: begin
                    // Frozen; the core stays out of reset so its state can be inspected.
                end
                default: begin
                    state_q <= StHold;
                end
            endcase
        end
    end

    assign o_core_rst_n = rst_n_q;
    assign o_running    = running_q;
    assign o_done       = done_q;
    assign o_status     = status_q;
    assign o_cycle_cnt  = cycle_cnt_q;
    assign o_insn_cnt   = insn_cnt_q;

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Synthesizable run controller for the pipelined core's simulation and FPGA bring-up. It generates a parametrised, staged set of active-low core resets from the single board reset, then monitors the retirement stream (`i_pc_debug`, `i_insn_vld`). It counts cycles and retired instructions and declares end-of-run as PASS (halt PC retired), STALL (no retirement for too long) or TIMEOUT. It sits between the top-level reset/clock and the `pipelined` core, replacing ad-hoc reset sequencing in benches.

## Interface
Parameters:
- `NUM_RST`, 2: number of staged core reset channels (≥1).
- `RST_CYCLES`, 4: cycles channel 0 is held in reset after `i_reset` deasserts (≥1).
- `STAGE_GAP`, 2: extra cycles between consecutive channel releases (≥0).
- `HALT_PC`, 32'h0000_0FFC: PC whose retirement ends the run with PASS.
- `STALL_LIMIT`, 16: consecutive RUN cycles without `i_insn_vld` that declare STALL (≥2).
- `TIMEOUT_CYCLES`, 100000: RUN cycles after which TIMEOUT is declared.
- `CNT_W`, 32: width of cycle and instruction counters.

Ports:
- `i_clk` in 1: single clock; all logic on the rising edge.
- `i_reset` in 1: synchronous, active-low reset.
- `i_pc_debug` in 32: PC of the instruction retiring this cycle.
- `i_insn_vld` in 1: a valid instruction retires this cycle.
- `o_core_rst_n` out NUM_RST: staged active-low resets to core sub-blocks.
- `o_running` out 1: high while in RUN.
- `o_done` out 1: sticky end-of-run flag.
- `o_status` out 2: 00 none, 01 PASS, 10 STALL, 11 TIMEOUT.
- `o_cycle_cnt` out CNT_W: RUN cycles elapsed.
- `o_insn_cnt` out CNT_W: instructions retired in RUN.

## Operation
- FSM states: HOLD → RUN → DONE. There is no path back except `i_reset` low.
- Reset (`i_reset` low at an edge) applies these values:
  - state=HOLD, all `o_core_rst_n`=0, `o_running`=0, `o_done`=0, `o_status`=00.
  - `o_cycle_cnt`=0, `o_insn_cnt`=0, hold and stall counters=0.
- HOLD:
  - The hold counter increments each cycle.
  - Channel k is released (`o_core_rst_n[k]`=1) once the counter reaches RST_CYCLES + k·STAGE_GAP. Channels release in index order and, once released, stay released.
  - When channel NUM_RST-1 is released, the FSM enters RUN on the same edge.
- RUN:
  - `o_cycle_cnt` increments every cycle.
  - `o_insn_cnt` increments on every `i_insn_vld`.
  - The stall counter clears on `i_insn_vld` and increments otherwise.
  - End conditions, evaluated each cycle in priority order:
    1. `i_insn_vld` && `i_pc_debug`==HALT_PC → PASS. That instruction is counted.
    2. The stall counter would reach STALL_LIMIT → STALL.
    3. `o_cycle_cnt` would reach TIMEOUT_CYCLES → TIMEOUT.
  - Any end condition moves the FSM to DONE, sets `o_status`, sets `o_done`=1 and `o_running`=0.
- DONE:
  - Counters freeze and `o_status` holds.
  - `o_core_rst_n` stays all-ones, so the core is not re-reset and its state stays inspectable.
  - Inputs are ignored.
- Counters saturate at all-ones rather than wrapping. TIMEOUT_CYCLES ≥ 2^CNT_W is therefore never reached; that is legal and disables timeout.

## Timing
- Edge 0 is the first rising edge at which `i_reset` is sampled high. `o_core_rst_n[k]` is a registered output and is high after edge RST_CYCLES-1 + k·STAGE_GAP (0-based).
- `o_running` rises on the same edge that `o_core_rst_n[NUM_RST-1]` rises.
- The end condition is detected combinationally from the current-cycle inputs. `o_done`, `o_status`, `o_running` and the final counts update on the following edge, so latency is 1 cycle.
- With STAGE_GAP=0, all channels release on the same edge.
- Reset mid-operation: `i_reset` low in any state returns all outputs to reset values on that edge. Deassertion restarts the full staged sequence.
- `i_insn_vld` during HOLD is ignored and not counted.
- If HALT_PC retires on the same cycle the stall or timeout limit is hit, PASS wins.

## Test plan
- Default params, `i_reset` low 3 cycles then high → `o_core_rst_n` goes 01 after edge 3 and 11 after edge 5; `o_running`=1 after edge 5; all outputs 0 before.
- RUN with `i_insn_vld` every cycle for 10 cycles, PCs 0,4,…; the last PC = HALT_PC → `o_status`=01, `o_done`=1, `o_insn_cnt`=10, `o_cycle_cnt`=10. Then 5 more `i_insn_vld` → counts unchanged.
- In RUN, retire 3 instructions then hold `i_insn_vld`=0 → STALL (10) declared one edge after the 16th idle cycle; `o_insn_cnt`=3.
- TIMEOUT_CYCLES=50, `i_insn_vld` toggled every other cycle, no HALT_PC → `o_status`=11 with `o_cycle_cnt`=50, `o_insn_cnt`=25.
- HALT_PC retired in the cycle that also hits STALL_LIMIT → `o_status`=01.
- `i_reset` pulsed low for 1 cycle during RUN and again in DONE → every output returns to its reset value, and the staged release repeats with identical timing.
